// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, line/frame total helper
// and RGB packing helpers shared by the VGA sync blocks.
package vga_timing_pkg;

  typedef logic [11:0] rgb_t;

  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam int unsigned DEF_COORD_W   = 10;
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam rgb_t BLACK = 12'h000;
  localparam rgb_t WHITE = 12'hFFF;

  // Total period of one axis (visible + porches + sync).
  function automatic int unsigned line_total(input int unsigned disp, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

  // Colour of test bar k: each nibble is all-ones or all-zeros from one bit of k.
  function automatic rgb_t bar_colour(input logic [2:0] k);
    return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: one-clk-wide pixel enable every CLK_DIV system clocks.
module vga_pixel_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_pixel_tick: CLK_DIV must be >= 1");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Wrapping divider count.
  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  // Tick is registered from the next count so it is low during reset even when CLK_DIV = 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      p_tick <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      p_tick <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator with frame-latched colour.
// Optional feature macro: VGA_TEST_PATTERN_EN (8 vertical colour bars on pattern_sel).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned COORD_W   = DEF_COORD_W,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        sw,
  input  logic               pattern_sel,
  output logic               p_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [11:0]        rgb
);

  localparam int unsigned H_TOTAL = line_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = line_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if ((((H_TOTAL - 1) >> COORD_W) != 0) || (((V_TOTAL - 1) >> COORD_W) != 0)) begin : g_coord_check
    $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  logic [COORD_W-1:0] h_next;
  logic [COORD_W-1:0] v_next;
  logic               line_wrap;
  logic               frame_wrap;
  rgb_t               colour;

  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Next-state position; only moves on a pixel tick.
  always_comb begin
    line_wrap  = p_tick && (h_count == H_LAST);
    frame_wrap = line_wrap && (v_count == V_LAST);
    h_next     = h_count;
    v_next     = v_count;
    if (p_tick) begin
      h_next = line_wrap ? '0 : h_count + 1'b1;
      if (line_wrap) begin
        v_next = frame_wrap ? '0 : v_count + 1'b1;
      end
    end
  end

  // Position, decode and pulse registers; decode uses next state so it lines up with pixel_x/y.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_count     <= '0;
      v_count     <= '0;
      hsync       <= !H_POL;
      vsync       <= !V_POL;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_count     <= h_next;
      v_count     <= v_next;
      hsync       <= ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? H_POL : !H_POL;
      vsync       <= ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? V_POL : !V_POL;
      video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
      line_start  <= line_wrap;
      frame_start <= frame_wrap;
    end
  end

  // Colour only changes at the frame boundary so the picture never tears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      colour <= BLACK;
    end else if (frame_wrap) begin
      colour <= sw;
    end
  end

  assign pixel_x = h_count;
  assign pixel_y = v_count;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = ((H_DISPLAY / 8) > 0) ? (H_DISPLAY / 8) : 1;

  logic [2:0] bar;

  // Bar index from the horizontal position.
  always_comb begin
    bar = 3'(pixel_x / COORD_W'(BAR_W));
  end

  // Pixel colour: test bars bypass the colour register; blanking still applies.
  always_comb begin
    rgb = BLACK;
    if (video_on) begin
      rgb = pattern_sel ? bar_colour(bar) : colour;
    end
  end
`else
  logic unused_pattern_sel;

  // pattern_sel has no function in this build.
  always_comb begin
    unused_pattern_sel = pattern_sel;
  end

  // Pixel colour gated by the visible area.
  always_comb begin
    rgb = BLACK;
    if (video_on) begin
      rgb = colour;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three vga_sync_gen instances (default, tiny CLK_DIV=1, odd CLK_DIV=3 with
// active-high syncs) checked every clk against a closed-form position model via a scoreboard.
module tb_vga_sync_gen;

  typedef struct {
    int d;
    int hd, hf, hs, hb;
    int vd, vf, vs, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic        p_tick;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        line_start;
    logic        frame_start;
    logic [15:0] x;
    logic [15:0] y;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    int   id;
    exp_t e;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [11:0] sw;
  logic        pattern_sel;

  logic a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [11:0] a_rgb;
  logic b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic [11:0] b_rgb;
  logic c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
  logic [4:0] c_x, c_y;
  logic [11:0] c_rgb;

  vga_sync_gen dut_a (
    .clk(clk), .reset(reset), .sw(sw), .pattern_sel(pattern_sel),
    .p_tick(a_tick), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
    .line_start(a_ls), .frame_start(a_fs), .pixel_x(a_x), .pixel_y(a_y), .rgb(a_rgb)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .COORD_W(4),
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_b (
    .clk(clk), .reset(reset), .sw(sw), .pattern_sel(pattern_sel),
    .p_tick(b_tick), .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
    .line_start(b_ls), .frame_start(b_fs), .pixel_x(b_x), .pixel_y(b_y), .rgb(b_rgb)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .COORD_W(5),
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_c (
    .clk(clk), .reset(reset), .sw(sw), .pattern_sel(pattern_sel),
    .p_tick(c_tick), .hsync(c_hs), .vsync(c_vs), .video_on(c_von),
    .line_start(c_ls), .frame_start(c_fs), .pixel_x(c_x), .pixel_y(c_y), .rgb(c_rgb)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  cfg_t        cfg[3];
  int          k[3];
  logic [11:0] col[3];
  sb_t         sb[$];
  string       names[3] = '{"A", "B", "C"};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pixel advances completed after k post-reset edges: an advance happens at edge j
  // when the tick seen before it was high, i.e. j >= 2 and j a multiple of the divider.
  function automatic int pix(input int kk, input int d);
    if (kk < 2) return 0;
    return (d == 1) ? kk - 1 : kk / d;
  endfunction

  function automatic bit is_adv(input int kk, input int d);
    return (kk >= 2) && (kk % d == 0);
  endfunction

  function automatic exp_t model(input cfg_t c, input int kk, input logic [11:0] cl, input logic pat);
    exp_t e;
    int ht, vt, p, h, v;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    p  = pix(kk, c.d);
    h  = p % ht;
    v  = (p / ht) % vt;
    e.p_tick      = (kk >= 1) && (kk % c.d == c.d - 1);
    e.line_start  = is_adv(kk, c.d) && (h == 0);
    e.frame_start = e.line_start && (v == 0);
    e.video_on    = (h < c.hd) && (v < c.vd);
    e.hsync       = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.hp : ~c.hp;
    e.vsync       = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.vp : ~c.vp;
    e.x           = 16'(h);
    e.y           = 16'(v);
    e.rgb         = 12'h000;
    if (e.video_on) begin
      e.rgb = cl;
`ifdef VGA_TEST_PATTERN_EN
      if (pat) begin
        int bw, b;
        bw = (c.hd / 8 > 0) ? c.hd / 8 : 1;
        b  = (h / bw) % 8;
        e.rgb = {(b & 4) != 0 ? 4'hF : 4'h0, (b & 2) != 0 ? 4'hF : 4'h0, (b & 1) != 0 ? 4'hF : 4'h0};
      end
`else
      if (pat) e.rgb = cl;
`endif
    end
    return e;
  endfunction

  function automatic exp_t observe(input int id);
    exp_t o;
    case (id)
      0:       o = {a_tick, a_hs, a_vs, a_von, a_ls, a_fs, 16'(a_x), 16'(a_y), a_rgb};
      1:       o = {b_tick, b_hs, b_vs, b_von, b_ls, b_fs, 16'(b_x), 16'(b_y), b_rgb};
      default: o = {c_tick, c_hs, c_vs, c_von, c_ls, c_fs, 16'(c_x), 16'(c_y), c_rgb};
    endcase
    return o;
  endfunction

  // Drive one clk of stimulus, push the expected post-edge state, then pop and compare.
  task automatic step(input logic rst_v, input logic [11:0] sw_v, input logic pat_v);
    sb_t  s;
    exp_t o;
    int   ft;
    reset       = rst_v;
    sw          = sw_v;
    pattern_sel = pat_v;
    for (int i = 0; i < 3; i++) begin
      if (!rst_v) begin
        k[i]   = 0;
        col[i] = 12'h000;
      end else begin
        k[i]++;
        ft = (cfg[i].hd + cfg[i].hf + cfg[i].hs + cfg[i].hb) *
             (cfg[i].vd + cfg[i].vf + cfg[i].vs + cfg[i].vb);
        if (is_adv(k[i], cfg[i].d) && (pix(k[i], cfg[i].d) % ft == 0)) col[i] = sw_v;
      end
      s.id = i;
      s.e  = model(cfg[i], k[i], col[i], pat_v);
      sb.push_back(s);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      o = observe(s.id);
      check_eq($sformatf("%s.p_tick", names[s.id]), 32'(o.p_tick), 32'(s.e.p_tick));
      check_eq($sformatf("%s.hsync", names[s.id]), 32'(o.hsync), 32'(s.e.hsync));
      check_eq($sformatf("%s.vsync", names[s.id]), 32'(o.vsync), 32'(s.e.vsync));
      check_eq($sformatf("%s.video_on", names[s.id]), 32'(o.video_on), 32'(s.e.video_on));
      check_eq($sformatf("%s.line_start", names[s.id]), 32'(o.line_start), 32'(s.e.line_start));
      check_eq($sformatf("%s.frame_start", names[s.id]), 32'(o.frame_start), 32'(s.e.frame_start));
      check_eq($sformatf("%s.pixel_x", names[s.id]), 32'(o.x), 32'(s.e.x));
      check_eq($sformatf("%s.pixel_y", names[s.id]), 32'(o.y), 32'(s.e.y));
      check_eq($sformatf("%s.rgb", names[s.id]), 32'(o.rgb), 32'(s.e.rgb));
    end
  endtask

  initial begin
    logic [11:0] cur_sw;
    logic        cur_pat;
    cfg[0] = '{d:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};
    cfg[1] = '{d:1, hd:4, hf:1, hs:2, hb:1, vd:3, vf:1, vs:1, vb:1, hp:1'b0, vp:1'b0};
    cfg[2] = '{d:3, hd:8, hf:2, hs:3, hb:2, vd:4, vf:1, vs:2, vb:1, hp:1'b1, vp:1'b1};
    for (int i = 0; i < 3; i++) begin
      k[i]   = 0;
      col[i] = 12'h000;
    end
    reset       = 1'b0;
    sw          = 12'h000;
    pattern_sel = 1'b0;

    repeat (3) step(1'b0, 12'h123, 1'b0);

    // Two full default lines; colour requests change mid-frame and near wraps of the small instances.
    cur_sw = 12'hF00;
    for (int n = 0; n < 7000; n++) begin
      if (n == 30) cur_sw = 12'h0F0;
      else if (n % 23 == 7) cur_sw = 12'($urandom);
      cur_pat = (n >= 3200 && n < 6400) ? 1'b1 : 1'b0;
      step(1'b1, cur_sw, cur_pat);
    end

    // Reset in the middle of a line/frame, then resume past the next default hsync and line wrap.
    step(1'b0, cur_sw, 1'b0);
    for (int n = 0; n < 3500; n++) begin
      if (n % 31 == 5) cur_sw = 12'($urandom);
      if (n % 400 == 0) cur_pat = 1'($urandom_range(0, 1));
      step(1'b1, cur_sw, cur_pat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 640x480 sync block used by the Pong game.
- Derives a pixel-rate clock enable from the system clock, runs horizontal/vertical counters, and decodes hsync, vsync, video_on, line_start and frame_start.
- Drives a 12-bit RGB output gated by video_on. The colour is latched from the switches only at frame boundaries, so the picture never tears mid-frame.
- Sits between the top-level clock/switch inputs and the VGA connector; the pixel/object generators consume pixel_x, pixel_y and p_tick.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz to 25 MHz); must be >= 1.
- COORD_W, 10, width of pixel_x/pixel_y and the internal counters.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines.
- H_POL, 0, hsync active level (0 = active-low).
- V_POL, 0, vsync active level.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- sw  input  12  requested colour {R[3:0],G[3:0],B[3:0]}.
- pattern_sel  input  1  test-pattern select; ignored unless VGA_TEST_PATTERN_EN is defined.
- p_tick  output  1  pixel clock enable, one clk wide.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.
- video_on  output  1  high inside the visible area.
- line_start  output  1  one-clk pulse when h_count wraps to 0.
- frame_start  output  1  one-clk pulse when (h,v) wraps to (0,0).
- pixel_x  output  COORD_W  current horizontal count.
- pixel_y  output  COORD_W  current vertical count.
- rgb  output  12  pixel colour.

Behaviour:
- Reset (reset==0 at a clk edge):
  - tick counter, h_count, v_count and colour register = 0.
  - p_tick, line_start, frame_start = 0.
  - hsync = !H_POL, vsync = !V_POL, video_on = 1 (decode of position (0,0)).
  - rgb = 0.
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Both must fit in COORD_W bits; a static check fails elaboration otherwise.
- Tick counter: counts 0..CLK_DIV-1 and wraps. p_tick = 1 in the clk where the count is CLK_DIV-1. With CLK_DIV=1, p_tick is constantly 1 after reset.
- Counters: advance only on p_tick.
  - h_count wraps from H_TOTAL-1 to 0.
  - v_count increments on that same edge and wraps from V_TOTAL-1 to 0.
- Decode:
  - hsync, vsync and video_on are registered, computed from next-state counters, so they are zero-skew with pixel_x/pixel_y.
  - hsync active when h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vsync active when v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
  - video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
- Pulses:
  - line_start = 1 for exactly one clk, the clk following the edge where h wrapped to 0.
  - frame_start = 1 likewise when both h and v wrapped; it coincides with a line_start.
- Colour:
  - colour register loads sw on the edge where (h,v) wraps to (0,0); sw changes mid-frame take effect at the next frame.
  - rgb = video_on ? colour : 12'h000 (combinational from registers).
- pixel_x/pixel_y equal h_count/v_count directly; they are undefined for drawing while video_on = 0.
- Reset mid-frame: everything returns to (0,0) on the next clk and the colour reverts to 0 until the next frame boundary.

Optional Feature:
- VGA_TEST_PATTERN_EN
- Defined: when pattern_sel = 1, rgb in the visible area is one of 8 vertical colour bars. bar = pixel_x / (H_DISPLAY/8); bar k gives R,G,B nibbles = {4{k[2]}},{4{k[1]}},{4{k[0]}}. The colour register is bypassed; video_on gating still applies.
- Undefined: pattern_sel is ignored and there is no bar logic.

Decomposition:
- Shared package vga_timing_pkg: default 640x480@60 timing constants, H_TOTAL/V_TOTAL helper, RGB nibble-packing constants (BLACK = 12'h000, WHITE = 12'hFFF).
- One sub-module, vga_pixel_tick: parametrised CLK_DIV enable generator with synchronous active-low reset.

Test Plan:
- Default parameters, reset released: first p_tick at clk 4 and every 4 clks after. hsync low for 96 ticks starting at pixel_x = 656. One line = 3200 clks.
- Default parameters, vertical timing: vsync low exactly on lines 490-491. frame_start period = 800*525*4 = 1,680,000 clks. line_start count per frame = 525.
- Small parameters (CLK_DIV=1; H=4/1/2/1; V=3/1/1/1): verify the exact wrap h 7 to 0 with v increment, v 5 to 0, and video_on = 0 for h >= 4 or v >= 3.
- sw = 12'hF00 mid-frame, then 12'h0F0 just before wrap: rgb changes only after frame_start and equals 12'h000 whenever video_on = 0.
- Assert reset (drive low) at (h=300, v=200): next clk h = v = 0, rgb = 0, hsync = vsync = 1. Resume counting after reset returns high.
- With VGA_TEST_PATTERN_EN and pattern_sel = 1: pixel_x = 0 gives 12'h000, pixel_x = 80 gives 12'h00F, pixel_x = 560 gives 12'hFFF.
